axi_lite_cmd_master: RTL and testbench

//  Converts a simple valid/ready command stream into single AXI4-Lite transactions on a master port.

---
 rtl/axi_lite_cmd_master_pkg.sv | 27 ++
 rtl/axi_lite_cmd_master_if.sv | 59 +++++
 rtl/axi_lite_cmd_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types for the AXI4-Lite command master: response codes and FSM states.
package axi_lite_cmd_master_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    CM_IDLE  = 3'd0,
    CM_WR    = 3'd1,
    CM_WR_B  = 3'd2,
    CM_RD_AR = 3'd3,
    CM_RD_R  = 3'd4,
    CM_RSP   = 3'd5
  } cm_state_t;

  localparam int RESP_W = 2;

  // Anything other than OKAY counts as an error response.
  function automatic logic resp_is_err(resp_t r);
    return (r != OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a downstream slave.
interface axi_lite_cmd_master_if
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  resp_t               bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  resp_t               rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// Turns a valid/ready command stream into single AXI4-Lite transactions, one
// outstanding at a time, and returns one response per command.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  CM_IDLE  | cmd_ready=1, waiting for a command
//  CM_WR    | AWVALID/WVALID presented, each dropped after its handshake
//  CM_WR_B  | both write channels done, BREADY=1 waiting for BVALID
//  CM_RD_AR | ARVALID presented, waiting for ARREADY
//  CM_RD_R  | RREADY=1 waiting for RVALID
//  CM_RSP   | rsp_valid=1 with stable rsp_*, waiting for rsp_ready
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int         AXI_DATA_WIDTH = 32,
  parameter int         AXI_ADDR_WIDTH = 32,
  parameter logic [2:0] AXI_PROT       = 3'b000,
  parameter int         ERR_CNT_WIDTH  = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [RESP_W-1:0]             rsp_resp,

  output logic [ERR_CNT_WIDTH-1:0]      err_count,

  axi_lite_cmd_master_if.master         m_axi
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "axi_lite_cmd_master: AXI_DATA_WIDTH must be 32 or 64");
  end

  cm_state_t                  state_q, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_nxt;
  logic [AXI_DATA_WIDTH-1:0]  wdata_q, wdata_nxt;
  logic [STRB_W-1:0]          wstrb_q, wstrb_nxt;

  logic                       cmd_ready_q, cmd_ready_nxt;
  logic                       awvalid_q, awvalid_nxt;
  logic                       wvalid_q, wvalid_nxt;
  logic                       aw_done_q, aw_done_nxt;
  logic                       w_done_q, w_done_nxt;
  logic                       bready_q, bready_nxt;
  logic                       arvalid_q, arvalid_nxt;
  logic                       rready_q, rready_nxt;

  logic                       rsp_valid_q, rsp_valid_nxt;
  logic                       rsp_write_q, rsp_write_nxt;
  logic [AXI_DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_nxt;
  resp_t                      rsp_resp_q, rsp_resp_nxt;
  logic                       rsp_load;

  logic [ERR_CNT_WIDTH-1:0]   err_count_q, err_count_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q && m_axi.awready;
  assign w_hs  = wvalid_q  && m_axi.wready;
  assign b_hs  = bready_q  && m_axi.bvalid;
  assign ar_hs = arvalid_q && m_axi.arready;
  assign r_hs  = rready_q  && m_axi.rvalid;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    state_nxt     = state_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    wstrb_nxt     = wstrb_q;
    cmd_ready_nxt = cmd_ready_q;
    awvalid_nxt   = awvalid_q;
    wvalid_nxt    = wvalid_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    bready_nxt    = bready_q;
    arvalid_nxt   = arvalid_q;
    rready_nxt    = rready_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_write_nxt = rsp_write_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_resp_nxt  = rsp_resp_q;
    rsp_load      = 1'b0;
    err_count_nxt = err_count_q;

    case (state_q)
      CM_IDLE: begin
        // cmd_ready comes up one cycle after reset release or after RSP.
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_nxt = 1'b0;
          addr_nxt      = cmd_addr;
          wdata_nxt     = cmd_wdata;
          wstrb_nxt     = cmd_wstrb;
          if (cmd_write) begin
            state_nxt   = CM_WR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end else begin
            state_nxt   = CM_RD_AR;
            arvalid_nxt = 1'b1;
          end
        end else begin
          cmd_ready_nxt = 1'b1;
        end
      end

      CM_WR: begin
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_nxt  = CM_WR_B;
          bready_nxt = 1'b1;
        end
      end

      CM_WR_B: begin
        if (b_hs) begin
          bready_nxt    = 1'b0;
          state_nxt     = CM_RSP;
          rsp_load      = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_resp_nxt  = m_axi.bresp;
        end
      end

      CM_RD_AR: begin
        if (ar_hs) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = CM_RD_R;
        end
      end

      CM_RD_R: begin
        if (r_hs) begin
          rready_nxt    = 1'b0;
          state_nxt     = CM_RSP;
          rsp_load      = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_rdata_nxt = m_axi.rdata;
          rsp_resp_nxt  = m_axi.rresp;
        end
      end

      CM_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = CM_IDLE;
        end
      end

      default: begin
        state_nxt = CM_IDLE;
      end
    endcase

    // Counted once per response, on entry to CM_RSP; holds at all-ones.
    if (rsp_load && resp_is_err(rsp_resp_nxt) && (err_count_q != ERR_MAX)) begin
      err_count_nxt = err_count_q + 1'b1;
    end
  end

  // State and output registers; reset drops every VALID/READY on the next edge.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= CM_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      err_count_q <= '0;
    end else begin
      state_q     <= state_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      wstrb_q     <= wstrb_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      awvalid_q   <= awvalid_nxt;
      wvalid_q    <= wvalid_nxt;
      aw_done_q   <= aw_done_nxt;
      w_done_q    <= w_done_nxt;
      bready_q    <= bready_nxt;
      arvalid_q   <= arvalid_nxt;
      rready_q    <= rready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_write_q <= rsp_write_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_resp_q  <= rsp_resp_nxt;
      err_count_q <= err_count_nxt;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;

  // Address/data come from the latched command so they stay stable under VALID.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: behavioural 4-register slave with per-channel
// stall control, response scoreboard and write-channel protocol monitor.
module tb_axi_lite_cmd_master;
  import axi_lite_cmd_master_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [EW-1:0]   err_count;

  axi_lite_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_cmd_master #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_PROT      (3'b000),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .err_count   (err_count),
    .m_axi       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int              aw_lat, w_lat, ar_lat;
  logic            b_err;
  int              aw_cnt, w_cnt, ar_cnt;
  logic            aw_got, w_got;
  logic [AW-1:0]   aw_addr_l;
  logic [DW-1:0]   w_data_l;
  logic [DW/8-1:0] w_strb_l;
  logic [DW-1:0]   mem [4];

  logic            s_aw_hs, s_w_hs, s_aw_n, s_w_n;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_data;
  logic [DW/8-1:0] s_strb;

  assign s_aw_hs = bus.awvalid && bus.awready;
  assign s_w_hs  = bus.wvalid && bus.wready;
  assign s_aw_n  = aw_got || s_aw_hs;
  assign s_w_n   = w_got || s_w_hs;
  assign s_addr  = s_aw_hs ? bus.awaddr : aw_addr_l;
  assign s_data  = s_w_hs ? bus.wdata : w_data_l;
  assign s_strb  = s_w_hs ? bus.wstrb : w_strb_l;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= OKAY;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= OKAY;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      bus.awready <= 1'b0;
      if (bus.awvalid && !bus.awready && !aw_got) begin
        if (aw_cnt >= aw_lat) begin bus.awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      bus.wready <= 1'b0;
      if (bus.wvalid && !bus.wready && !w_got) begin
        if (w_cnt >= w_lat) begin bus.wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (s_aw_hs) aw_addr_l <= bus.awaddr;
      if (s_w_hs) begin w_data_l <= bus.wdata; w_strb_l <= bus.wstrb; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (s_aw_n && s_w_n) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= b_err ? SLVERR : OKAY;
        if (!b_err)
          for (int i = 0; i < DW/8; i++)
            if (s_strb[i]) mem[s_addr[3:2]][i*8 +: 8] <= s_data[i*8 +: 8];
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= s_aw_n;
        w_got  <= s_w_n;
      end
      bus.arready <= 1'b0;
      if (bus.arvalid && !bus.arready) begin
        if (ar_cnt >= ar_lat) begin bus.arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= mem[bus.araddr[3:2]];
        bus.rresp  <= OKAY;
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct packed {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   rsp_cnt = 0;
  int   n_exp_rsp = 0;

  logic          mon_en = 1'b0;
  logic          aw_seen = 1'b0, w_seen = 1'b0;
  logic          p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_bready = 1'b0;
  logic [AW-1:0] p_awaddr;
  logic [DW-1:0] p_wdata;

  initial forever begin
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      chk_val("sb_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk_val("rsp_write", rsp_write, sb_e.write);
        chk_val("rsp_rdata", rsp_rdata, sb_e.rdata);
        chk_val("rsp_resp", rsp_resp, sb_e.resp);
      end
      rsp_cnt++;
    end
    if (!rst && (bus.awvalid || bus.wvalid || bus.bready || bus.arvalid || bus.rready || rsp_valid))
      chk_val("cmd_ready_busy", cmd_ready, 1'b0);
    if (mon_en) begin
      if (p_awv && p_awr) begin
        chk_val("aw_drop", bus.awvalid, 1'b0);
        aw_seen = 1'b1;
      end else if (p_awv) begin
        chk_val("aw_hold", bus.awvalid, 1'b1);
        chk_val("aw_addr_stable", bus.awaddr, p_awaddr);
      end
      if (p_wv && p_wr) begin
        chk_val("w_drop", bus.wvalid, 1'b0);
        w_seen = 1'b1;
      end else if (p_wv) begin
        chk_val("w_hold", bus.wvalid, 1'b1);
        chk_val("w_data_stable", bus.wdata, p_wdata);
      end
      if (bus.bready && !p_bready) begin
        chk_val("bready_after_both", {aw_seen, w_seen}, 2'b11);
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
    end
    p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
    p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wdata  = bus.wdata;
    p_bready = bus.bready;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input logic [DW-1:0] exp_rd,
                           input logic [1:0] exp_resp);
    exp_t e;
    sync();
    e.write = wr;
    e.rdata = exp_rd;
    e.resp  = exp_resp;
    exp_q.push_back(e);
    n_exp_rsp++;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_val("cmd_accept", cmd_ready, 1'b1);
    if (cmd_ready) sync();
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic [DW-1:0] exp_rd,
                          input logic [1:0] exp_resp);
    drive_cmd(wr, a, d, s, exp_rd, exp_resp);
    wait_accept();
  endtask

  task automatic wait_all();
    int n = 0;
    while (rsp_cnt < n_exp_rsp && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk_val("rsp_count", rsp_cnt, n_exp_rsp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] wr_data [4];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_err = 1'b0;
    wr_data[0] = 32'hDEADBEEF; wr_data[1] = 32'hBAADF00D;
    wr_data[2] = 32'hFEEDFACE; wr_data[3] = 32'h0BADC0DE;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("rst_cmd_ready", cmd_ready, 1'b0);
    chk_val("rst_awvalid", bus.awvalid, 1'b0);
    chk_val("rst_wvalid", bus.wvalid, 1'b0);
    chk_val("rst_arvalid", bus.arvalid, 1'b0);
    chk_val("rst_bready", bus.bready, 1'b0);
    chk_val("rst_rready", bus.rready, 1'b0);
    chk_val("rst_rsp_valid", rsp_valid, 1'b0);
    chk_val("rst_rsp_rdata", rsp_rdata, '0);
    chk_val("rst_err_count", err_count, '0);
    rst = 1'b0;
    @(negedge clk);
    chk_val("ready_after_rst", cmd_ready, 1'b1);
    mon_en = 1'b1;

    // write then read back one word
    send_cmd(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, '0, OKAY);
    send_cmd(1'b0, 32'h0, '0, 4'h0, 32'hDEADBEEF, OKAY);
    wait_all();
    chk_val("t1_err_count", err_count, '0);

    // four writes then four reads, back to back
    for (int i = 0; i < 4; i++) send_cmd(1'b1, 32'(i*4), wr_data[i], 4'hF, '0, OKAY);
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 32'(i*4), '0, 4'h0, wr_data[i], OKAY);
    wait_all();
    chk_val("t2_err_count", err_count, '0);

    // W before AW, then AW before W
    aw_lat = 3; w_lat = 0;
    send_cmd(1'b1, 32'h4, 32'h11112222, 4'hF, '0, OKAY);
    wait_all();
    aw_lat = 0; w_lat = 3;
    send_cmd(1'b1, 32'h8, 32'h33334444, 4'hF, '0, OKAY);
    wait_all();
    aw_lat = 0; w_lat = 0;

    // response back-pressure with a second command waiting
    sync();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h4, '0, 4'h0, 32'h11112222, OKAY);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk_val("t4_rsp_valid_up", rsp_valid, 1'b1);
    drive_cmd(1'b0, 32'h8, '0, 4'h0, 32'h33334444, OKAY);
    repeat (6) begin
      @(negedge clk);
      chk_val("t4_hold_valid", rsp_valid, 1'b1);
      chk_val("t4_hold_rdata", rsp_rdata, 32'h11112222);
      chk_val("t4_hold_cmd_ready", cmd_ready, 1'b0);
      chk_val("t4_no_arvalid", bus.arvalid, 1'b0);
    end
    sync();
    rsp_ready = 1'b1;
    wait_accept();
    wait_all();

    // SLVERR responses saturate a 2-bit counter at 3
    b_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b1, 32'hC, 32'h55555555, 4'hF, '0, SLVERR);
      wait_all();
      chk_val("t5_err_count", err_count, (i < 3) ? i + 1 : 3);
    end
    b_err = 1'b0;

    // reset while AWVALID is stalled
    mon_en = 1'b0;
    aw_lat = 20;
    send_cmd(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, '0, OKAY);
    @(negedge clk);
    chk_val("t6_awvalid_pre", bus.awvalid, 1'b1);
    chk_val("t6_awready_pre", bus.awready, 1'b0);
    rst = 1'b1;
    void'(exp_q.pop_back());
    n_exp_rsp--;
    @(negedge clk);
    chk_val("t6_awvalid", bus.awvalid, 1'b0);
    chk_val("t6_wvalid", bus.wvalid, 1'b0);
    chk_val("t6_arvalid", bus.arvalid, 1'b0);
    chk_val("t6_bready", bus.bready, 1'b0);
    chk_val("t6_rsp_valid", rsp_valid, 1'b0);
    chk_val("t6_err_count", err_count, '0);
    rst = 1'b0;
    aw_lat = 0;
    @(negedge clk);
    chk_val("t6_ready_after", cmd_ready, 1'b1);
    send_cmd(1'b1, 32'h0, 32'h0F0F0F0F, 4'hF, '0, OKAY);
    send_cmd(1'b0, 32'h0, '0, 4'h0, 32'h0F0F0F0F, OKAY);
    wait_all();
    chk_val("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
